axi_lite_slave_regs: RTL and testbench

//  AXI4-Lite slave register bank; sits directly downstream of axi_lite_master via axi_lite_if.slave.

---
 rtl/axi_lite_pkg.sv | 32 +++
 rtl/axi_lite_regbank.sv | 89 ++++++++
 rtl/axi_lite_slave_regs.sv | 184 ++++++++++++++++++
 tb/tb_axi_lite_slave_regs.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi_lite_pkg.sv
// Shared types for the AXI4-Lite register slave: bus field widths, response
// codes, channel FSM states and the address-to-word-index helper.
package axi_lite_pkg;

  typedef logic [11:0] addr_t;
  typedef logic [31:0] data_t;
  typedef logic [3:0]  strb_t;

  localparam int IDX_W = 10;
  typedef logic [IDX_W-1:0] idx_t;

  typedef enum logic [1:0] {
    RESP_OKAY   = 2'b00,
    RESP_SLVERR = 2'b10
  } resp_t;

  typedef enum logic {
    WS_IDLE,
    WS_RESP
  } wr_state_t;

  typedef enum logic {
    RS_IDLE,
    RS_DATA
  } rd_state_t;

  // Word index of a byte address; the two byte-offset bits are ignored.
  function automatic idx_t addr_to_idx(input addr_t addr);
    return addr[11:2];
  endfunction

endpackage

// File: rtl/axi_lite_regbank.sv
// Register storage for the AXI4-Lite slave. Word 0 is a constant ID value and
// is never stored; words 1..NUM_REGS-1 are flops with one write port and an
// asynchronous read port. Byte-lane write masking is built only when
// AXI_LITE_SLAVE_WSTRB_EN is defined; otherwise every write replaces the word.
module axi_lite_regbank
  import axi_lite_pkg::*;
#(
  parameter int    NUM_REGS = 8,
  parameter data_t ID_VALUE = 32'hA11E_0001
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     we,
  input  idx_t                     widx,
  input  data_t                    wdata,
  input  strb_t                    wstrb,
  input  idx_t                     ridx,
  output data_t                    rdata,
  output logic [NUM_REGS-1:0][31:0] regs_o
);

  data_t stor_q [NUM_REGS-1];
  data_t stor_d [NUM_REGS-1];
  data_t wmask;

`ifdef AXI_LITE_SLAVE_WSTRB_EN
  // Expand each strobe bit to a full byte of write mask.
  always_comb begin
    wmask = '0;
    for (int b = 0; b < 4; b++) begin
      wmask[8*b +: 8] = {8{wstrb[b]}};
    end
  end
`else
  logic unused_wstrb;
  assign unused_wstrb = ^wstrb;

  // Strobes are ignored in this build, so every write covers the whole word.
  always_comb begin
    wmask = '1;
  end
`endif

  // Merge the masked write data into the addressed stored word.
  always_comb begin
    for (int i = 0; i < NUM_REGS-1; i++) begin
      stor_d[i] = stor_q[i];
      if (we && (int'(widx) == i + 1)) begin
        stor_d[i] = (stor_q[i] & ~wmask) | (wdata & wmask);
      end
    end
  end

  // Stored words clear on reset and otherwise take the merged value.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REGS-1; i++) begin
        stor_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_REGS-1; i++) begin
        stor_q[i] <= stor_d[i];
      end
    end
  end

  // Async read: word 0 is the ID, out-of-range indices read as zero.
  always_comb begin
    rdata = '0;
    if (ridx == '0) begin
      rdata = ID_VALUE;
    end else begin
      for (int i = 0; i < NUM_REGS-1; i++) begin
        if (int'(ridx) == i + 1) begin
          rdata = stor_q[i];
        end
      end
    end
  end

  // Export the full register image with the ID in slot 0.
  always_comb begin
    regs_o[0] = ID_VALUE;
    for (int i = 0; i < NUM_REGS-1; i++) begin
      regs_o[i+1] = stor_q[i];
    end
  end

endmodule

// File: rtl/axi_lite_slave_regs.sv
// AXI4-Lite slave register bank. Independent write (AW/W/B) and read (AR/R)
// FSMs sit in front of an axi_lite_regbank. Word 0 is a read-only ID, writes
// to it or past the last register answer SLVERR. Optional byte-strobe writes
// are enabled by defining AXI_LITE_SLAVE_WSTRB_EN.
module axi_lite_slave_regs
  import axi_lite_pkg::*;
#(
  parameter int    NUM_REGS = 8,
  parameter data_t ID_VALUE = 32'hA11E_0001
) (
  input  logic                      aclk,
  input  logic                      areset_n,
  input  logic [11:0]               awaddr,
  input  logic                      awvalid,
  output logic                      awready,
  input  logic [31:0]               wdata,
  input  logic [3:0]                wstrb,
  input  logic                      wvalid,
  output logic                      wready,
  output logic [1:0]                bresp,
  output logic                      bvalid,
  input  logic                      bready,
  input  logic [11:0]               araddr,
  input  logic                      arvalid,
  output logic                      arready,
  output logic [31:0]               rdata,
  output logic [1:0]                rresp,
  output logic                      rvalid,
  input  logic                      rready,
  output logic [NUM_REGS-1:0][31:0] regs_o
);

  wr_state_t wr_state_q, wr_state_d;
  rd_state_t rd_state_q, rd_state_d;
  logic      aw_held_q, aw_held_d;
  logic      w_held_q, w_held_d;
  addr_t     awaddr_q, awaddr_d;
  data_t     wdata_q, wdata_d;
  strb_t     wstrb_q, wstrb_d;
  logic      bvalid_q, bvalid_d;
  resp_t     bresp_q, bresp_d;
  logic      rvalid_q, rvalid_d;
  data_t     rdata_q, rdata_d;
  resp_t     rresp_q, rresp_d;

  logic      bank_we;
  idx_t      wr_idx;
  data_t     wr_data;
  strb_t     wr_strb;
  idx_t      rd_idx;
  data_t     bank_rdata;

  axi_lite_regbank #(
    .NUM_REGS (NUM_REGS),
    .ID_VALUE (ID_VALUE)
  ) u_regbank (
    .clk    (aclk),
    .rst_n  (areset_n),
    .we     (bank_we),
    .widx   (wr_idx),
    .wdata  (wr_data),
    .wstrb  (wr_strb),
    .ridx   (rd_idx),
    .rdata  (bank_rdata),
    .regs_o (regs_o)
  );

  // State and datapath registers for both channels; reset drops any pending work.
  always_ff @(posedge aclk) begin
    if (!areset_n) begin
      wr_state_q <= WS_IDLE;
      rd_state_q <= RS_IDLE;
      aw_held_q  <= 1'b0;
      w_held_q   <= 1'b0;
      awaddr_q   <= '0;
      wdata_q    <= '0;
      wstrb_q    <= '0;
      bvalid_q   <= 1'b0;
      bresp_q    <= RESP_OKAY;
      rvalid_q   <= 1'b0;
      rdata_q    <= '0;
      rresp_q    <= RESP_OKAY;
    end else begin
      wr_state_q <= wr_state_d;
      rd_state_q <= rd_state_d;
      aw_held_q  <= aw_held_d;
      w_held_q   <= w_held_d;
      awaddr_q   <= awaddr_d;
      wdata_q    <= wdata_d;
      wstrb_q    <= wstrb_d;
      bvalid_q   <= bvalid_d;
      bresp_q    <= bresp_d;
      rvalid_q   <= rvalid_d;
      rdata_q    <= rdata_d;
      rresp_q    <= rresp_d;
    end
  end

  // Next-state logic: collect AW and W in either order, commit once both are
  // present, and capture read data in the AR handshake cycle.
  always_comb begin
    wr_state_d = wr_state_q;
    rd_state_d = rd_state_q;
    aw_held_d  = aw_held_q;
    w_held_d   = w_held_q;
    awaddr_d   = awaddr_q;
    wdata_d    = wdata_q;
    wstrb_d    = wstrb_q;
    bvalid_d   = bvalid_q;
    bresp_d    = bresp_q;
    rvalid_d   = rvalid_q;
    rdata_d    = rdata_q;
    rresp_d    = rresp_q;
    bank_we    = 1'b0;
    wr_idx     = addr_to_idx(aw_held_q ? awaddr_q : awaddr);
    wr_data    = w_held_q ? wdata_q : wdata;
    wr_strb    = w_held_q ? wstrb_q : wstrb;
    rd_idx     = addr_to_idx(araddr);

    case (wr_state_q)
      WS_IDLE: begin
        if (awvalid && awready) begin
          aw_held_d = 1'b1;
          awaddr_d  = awaddr;
        end
        if (wvalid && wready) begin
          w_held_d = 1'b1;
          wdata_d  = wdata;
          wstrb_d  = wstrb;
        end
        if ((aw_held_q || (awvalid && awready)) && (w_held_q || (wvalid && wready))) begin
          if ((wr_idx != '0) && (int'(wr_idx) < NUM_REGS)) begin
            bank_we = areset_n;
            bresp_d = RESP_OKAY;
          end else begin
            bresp_d = RESP_SLVERR;
          end
          bvalid_d   = 1'b1;
          aw_held_d  = 1'b0;
          w_held_d   = 1'b0;
          wr_state_d = WS_RESP;
        end
      end
      WS_RESP: begin
        if (bready) begin
          bvalid_d   = 1'b0;
          wr_state_d = WS_IDLE;
        end
      end
      default: wr_state_d = WS_IDLE;
    endcase

    case (rd_state_q)
      RS_IDLE: begin
        if (arvalid && arready) begin
          rdata_d    = bank_rdata;
          rresp_d    = (int'(rd_idx) < NUM_REGS) ? RESP_OKAY : RESP_SLVERR;
          rvalid_d   = 1'b1;
          rd_state_d = RS_DATA;
        end
      end
      RS_DATA: begin
        if (rready) begin
          rvalid_d   = 1'b0;
          rd_state_d = RS_IDLE;
        end
      end
      default: rd_state_d = RS_IDLE;
    endcase
  end

  // Channel outputs: readies follow the FSM states and are held low during reset.
  always_comb begin
    awready = areset_n && (wr_state_q == WS_IDLE) && !aw_held_q;
    wready  = areset_n && (wr_state_q == WS_IDLE) && !w_held_q;
    arready = areset_n && (rd_state_q == RS_IDLE);
    bvalid  = bvalid_q;
    bresp   = bresp_q;
    rvalid  = rvalid_q;
    rdata   = rdata_q;
    rresp   = rresp_q;
  end

endmodule

// File: tb/tb_axi_lite_slave_regs.sv
// Directed bench for axi_lite_slave_regs: reset state, ID read, writes in all
// AW/W orderings, SLVERR decode, R back-pressure, same-edge read/write,
// early bready, reset mid-transaction and the strobe behaviour selected by
// AXI_LITE_SLAVE_WSTRB_EN.
module tb_axi_lite_slave_regs;

  localparam int NUM_REGS = 8;
  localparam logic [1:0] OKAY   = 2'b00;
  localparam logic [1:0] SLVERR = 2'b10;

  logic                      aclk = 1'b0;
  logic                      areset_n;
  logic [11:0]               awaddr;
  logic                      awvalid;
  logic                      awready;
  logic [31:0]               wdata;
  logic [3:0]                wstrb;
  logic                      wvalid;
  logic                      wready;
  logic [1:0]                bresp;
  logic                      bvalid;
  logic                      bready;
  logic [11:0]               araddr;
  logic                      arvalid;
  logic                      arready;
  logic [31:0]               rdata;
  logic [1:0]                rresp;
  logic                      rvalid;
  logic                      rready;
  logic [NUM_REGS-1:0][31:0] regs_o;

  int vectors     = 0;
  int miscompares = 0;

  axi_lite_slave_regs #(
    .NUM_REGS (NUM_REGS),
    .ID_VALUE (32'hA11E_0001)
  ) dut (
    .aclk     (aclk),
    .areset_n (areset_n),
    .awaddr   (awaddr),
    .awvalid  (awvalid),
    .awready  (awready),
    .wdata    (wdata),
    .wstrb    (wstrb),
    .wvalid   (wvalid),
    .wready   (wready),
    .bresp    (bresp),
    .bvalid   (bvalid),
    .bready   (bready),
    .araddr   (araddr),
    .arvalid  (arvalid),
    .arready  (arready),
    .rdata    (rdata),
    .rresp    (rresp),
    .rvalid   (rvalid),
    .rready   (rready),
    .regs_o   (regs_o)
  );

  // 10 ns clock.
  always #5 aclk = ~aclk;

  // Advance n rising edges and settle 1 ns past the last one.
  task automatic applyStimulus(input int n);
    repeat (n) @(posedge aclk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    vectors++;
    assert (observed === expected)
    else begin
      miscompares++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Write with mode 0 = AW then W, 1 = W then AW, 2 = same cycle.
  task automatic doWrite(input string tag, input logic [11:0] addr, input logic [31:0] data,
                         input logic [3:0] strb, input int mode, output logic [1:0] resp);
    if (mode == 0) begin
      awaddr = addr; awvalid = 1'b1;
      applyStimulus(1);
      awvalid = 1'b0;
      checkOutput({tag, "_awready_after_aw"}, 64'(awready), 64'd0);
      wdata = data; wstrb = strb; wvalid = 1'b1;
      applyStimulus(1);
      wvalid = 1'b0;
    end else if (mode == 1) begin
      wdata = data; wstrb = strb; wvalid = 1'b1;
      applyStimulus(1);
      wvalid = 1'b0;
      checkOutput({tag, "_wready_after_w"}, 64'(wready), 64'd0);
      awaddr = addr; awvalid = 1'b1;
      applyStimulus(1);
      awvalid = 1'b0;
    end else begin
      awaddr = addr; awvalid = 1'b1;
      wdata = data; wstrb = strb; wvalid = 1'b1;
      applyStimulus(1);
      awvalid = 1'b0; wvalid = 1'b0;
    end
    checkOutput({tag, "_bvalid"}, 64'(bvalid), 64'd1);
    resp = bresp;
    bready = 1'b1;
    applyStimulus(1);
    bready = 1'b0;
    checkOutput({tag, "_bvalid_clear"}, 64'(bvalid), 64'd0);
  endtask

  // Single read with immediate rready; rvalid must appear one cycle after AR.
  task automatic doRead(input string tag, input logic [11:0] addr,
                        output logic [31:0] data, output logic [1:0] resp);
    checkOutput({tag, "_arready"}, 64'(arready), 64'd1);
    araddr = addr; arvalid = 1'b1;
    applyStimulus(1);
    arvalid = 1'b0;
    checkOutput({tag, "_rvalid"}, 64'(rvalid), 64'd1);
    data = rdata;
    resp = rresp;
    rready = 1'b1;
    applyStimulus(1);
    rready = 1'b0;
    checkOutput({tag, "_rvalid_clear"}, 64'(rvalid), 64'd0);
  endtask

  logic [31:0] rd;
  logic [1:0]  rsp;
  logic [31:0] strb_expect;

  initial begin
    areset_n = 1'b0;
    awaddr = '0; awvalid = 1'b0;
    wdata = '0; wstrb = '0; wvalid = 1'b0;
    bready = 1'b0;
    araddr = '0; arvalid = 1'b0;
    rready = 1'b0;
    applyStimulus(2);

    checkOutput("rst_awready", 64'(awready), 64'd0);
    checkOutput("rst_wready", 64'(wready), 64'd0);
    checkOutput("rst_arready", 64'(arready), 64'd0);
    checkOutput("rst_bvalid", 64'(bvalid), 64'd0);
    checkOutput("rst_rvalid", 64'(rvalid), 64'd0);
    checkOutput("rst_rdata", 64'(rdata), 64'd0);
    checkOutput("rst_bresp", 64'(bresp), 64'(OKAY));
    checkOutput("rst_reg1", 64'(regs_o[1]), 64'd0);
    checkOutput("rst_reg0", 64'(regs_o[0]), 64'hA11E_0001);

    areset_n = 1'b1;
    #1;
    checkOutput("idle_awready", 64'(awready), 64'd1);
    checkOutput("idle_wready", 64'(wready), 64'd1);

    doRead("rd_id", 12'h000, rd, rsp);
    checkOutput("rd_id_data", 64'(rd), 64'hA11E_0001);
    checkOutput("rd_id_resp", 64'(rsp), 64'(OKAY));

    doWrite("wr_reg1", 12'h004, 32'hDEAD_BEEF, 4'hF, 0, rsp);
    checkOutput("wr_reg1_resp", 64'(rsp), 64'(OKAY));
    checkOutput("wr_reg1_regs_o", 64'(regs_o[1]), 64'hDEAD_BEEF);
    doRead("rd_reg1", 12'h004, rd, rsp);
    checkOutput("rd_reg1_data", 64'(rd), 64'hDEAD_BEEF);
    checkOutput("rd_reg1_resp", 64'(rsp), 64'(OKAY));
    doRead("rd_reg1_offs", 12'h007, rd, rsp);
    checkOutput("rd_reg1_offs_data", 64'(rd), 64'hDEAD_BEEF);

    doWrite("wr_id", 12'h000, 32'h1111_2222, 4'hF, 0, rsp);
    checkOutput("wr_id_resp", 64'(rsp), 64'(SLVERR));
    doRead("rd_id2", 12'h000, rd, rsp);
    checkOutput("rd_id2_data", 64'(rd), 64'hA11E_0001);
    doWrite("wr_oor", 12'h040, 32'h3333_4444, 4'hF, 0, rsp);
    checkOutput("wr_oor_resp", 64'(rsp), 64'(SLVERR));
    doRead("rd_oor", 12'h040, rd, rsp);
    checkOutput("rd_oor_data", 64'(rd), 64'd0);
    checkOutput("rd_oor_resp", 64'(rsp), 64'(SLVERR));
    doRead("rd_last", 12'h01C, rd, rsp);
    checkOutput("rd_last_resp", 64'(rsp), 64'(OKAY));
    doRead("rd_first_oor", 12'h020, rd, rsp);
    checkOutput("rd_first_oor_resp", 64'(rsp), 64'(SLVERR));

    araddr = 12'h004; arvalid = 1'b1;
    applyStimulus(1);
    arvalid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      checkOutput("hold_rvalid", 64'(rvalid), 64'd1);
      checkOutput("hold_rdata", 64'(rdata), 64'hDEAD_BEEF);
      checkOutput("hold_arready", 64'(arready), 64'd0);
      applyStimulus(1);
    end
    rready = 1'b1;
    applyStimulus(1);
    rready = 1'b0;
    checkOutput("hold_rvalid_clear", 64'(rvalid), 64'd0);
    checkOutput("hold_arready_back", 64'(arready), 64'd1);

    doWrite("wr_w_first", 12'h008, 32'h1234_5678, 4'hF, 1, rsp);
    checkOutput("wr_w_first_resp", 64'(rsp), 64'(OKAY));
    doRead("rd_w_first", 12'h008, rd, rsp);
    checkOutput("rd_w_first_data", 64'(rd), 64'h1234_5678);
    doWrite("wr_same", 12'h008, 32'h8765_4321, 4'hF, 2, rsp);
    checkOutput("wr_same_resp", 64'(rsp), 64'(OKAY));
    doRead("rd_same", 12'h008, rd, rsp);
    checkOutput("rd_same_data", 64'(rd), 64'h8765_4321);

    awaddr = 12'h008; awvalid = 1'b1;
    wdata = 32'hCAFE_F00D; wstrb = 4'hF; wvalid = 1'b1;
    araddr = 12'h008; arvalid = 1'b1;
    applyStimulus(1);
    awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
    checkOutput("rw_bvalid", 64'(bvalid), 64'd1);
    checkOutput("rw_rvalid", 64'(rvalid), 64'd1);
    checkOutput("rw_pre_write_data", 64'(rdata), 64'h8765_4321);
    bready = 1'b1; rready = 1'b1;
    applyStimulus(1);
    bready = 1'b0; rready = 1'b0;
    doRead("rd_post_rw", 12'h008, rd, rsp);
    checkOutput("rd_post_rw_data", 64'(rd), 64'hCAFE_F00D);

    doWrite("wr_strb_full", 12'h00C, 32'hFFFF_FFFF, 4'hF, 0, rsp);
    doWrite("wr_strb_low", 12'h00C, 32'h0000_0000, 4'b0011, 0, rsp);
    checkOutput("wr_strb_resp", 64'(rsp), 64'(OKAY));
`ifdef AXI_LITE_SLAVE_WSTRB_EN
    strb_expect = 32'hFFFF_0000;
`else
    strb_expect = 32'h0000_0000;
`endif
    doRead("rd_strb", 12'h00C, rd, rsp);
    checkOutput("rd_strb_data", 64'(rd), 64'(strb_expect));
    checkOutput("strb_regs_o", 64'(regs_o[3]), 64'(strb_expect));

    bready = 1'b1;
    awaddr = 12'h010; awvalid = 1'b1;
    wdata = 32'h0000_1111; wstrb = 4'hF; wvalid = 1'b1;
    applyStimulus(1);
    awvalid = 1'b0; wvalid = 1'b0;
    checkOutput("early_bready_bvalid", 64'(bvalid), 64'd1);
    applyStimulus(1);
    bready = 1'b0;
    checkOutput("early_bready_clear", 64'(bvalid), 64'd0);
    checkOutput("early_bready_reg4", 64'(regs_o[4]), 64'h0000_1111);

    awaddr = 12'h014; awvalid = 1'b1;
    applyStimulus(1);
    awvalid = 1'b0;
    areset_n = 1'b0;
    applyStimulus(1);
    checkOutput("mid_rst_bvalid", 64'(bvalid), 64'd0);
    checkOutput("mid_rst_reg1", 64'(regs_o[1]), 64'd0);
    areset_n = 1'b1;
    #1;
    checkOutput("mid_rst_awready", 64'(awready), 64'd1);
    wdata = 32'h5555_AAAA; wstrb = 4'hF; wvalid = 1'b1;
    applyStimulus(1);
    wvalid = 1'b0;
    checkOutput("mid_rst_no_bvalid", 64'(bvalid), 64'd0);
    awaddr = 12'h01C; awvalid = 1'b1;
    applyStimulus(1);
    awvalid = 1'b0;
    checkOutput("mid_rst_bvalid_after_aw", 64'(bvalid), 64'd1);
    checkOutput("mid_rst_bresp", 64'(bresp), 64'(OKAY));
    bready = 1'b1;
    applyStimulus(1);
    bready = 1'b0;
    doRead("rd_after_rst", 12'h01C, rd, rsp);
    checkOutput("rd_after_rst_data", 64'(rd), 64'h5555_AAAA);
    checkOutput("discarded_reg5", 64'(regs_o[5]), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
